coproc0: RTL and testbench

COPROC0 -- requirements
Module: coproc0

---
 rtl/coproc0_pkg.sv | 25 ++
 rtl/coproc0.sv | 80 ++++++++
 tb/tb_coproc0.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/coproc0_pkg.sv
// coproc0_pkg: CP0 register numbers, exception codes, handler address and SR/Cause field positions
package coproc0_pkg;
  localparam logic [4:0] REG_SR = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC = 5'd14;
  localparam logic [4:0] REG_PRID = 5'd15;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam int SR_IE = 0;
  localparam int SR_EXL = 1;
  localparam int IM_LO = 10;
  localparam int IM_HI = 15;
  localparam int CAUSE_BD = 31;
  localparam int IP_LO = 10;
  localparam int IP_HI = 15;
  localparam int EXC_LO = 2;
  localparam int EXC_HI = 6;
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS = 5'd8,
    EXC_RI = 5'd10,
    EXC_OV = 5'd12
  } exc_code_e;
endpackage

// File: rtl/coproc0.sv
// coproc0: MIPS-style CP0 holding SR/Cause/EPC/PRId and raising interrupt/exception redirect requests
module coproc0
  import coproc0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h2022_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);
  logic [5:0] im_q, im_d, ip_q, ip_d;
  logic exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0] exc_q, exc_d;
  logic [31:0] epc_q, epc_d, sr_val, cause_val;
  logic int_req, exc_req, sr_wr, epc_wr;
  // request logic: masked while EXL is set, interrupts need IE and an enabled line
  always_comb begin
    int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
    Req = int_req | exc_req;
  end
  // next state: a request captures the victim and blocks mtc0; eret clears EXL after any SR write
  always_comb begin
    sr_wr = en & ~Req & (CP0Add == REG_SR);
    epc_wr = en & ~Req & (CP0Add == REG_EPC);
    im_d = sr_wr ? CP0In[IM_HI:IM_LO] : im_q;
    ie_d = sr_wr ? CP0In[SR_IE] : ie_q;
    exl_d = Req | (~EXLClr & (sr_wr ? CP0In[SR_EXL] : exl_q));
    bd_d = Req ? BDIn : bd_q;
    exc_d = Req ? (int_req ? EXC_INT : ExcCodeIn) : exc_q;
    epc_d = Req ? (BDIn ? VPC - 32'd4 : VPC) : epc_wr ? CP0In : epc_q;
    ip_d = HWInt;
  end
  // state registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q <= '0;
      ip_q <= '0;
      exl_q <= 1'b0;
      ie_q <= 1'b0;
      bd_q <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q <= im_d;
      ip_q <= ip_d;
      exl_q <= exl_d;
      ie_q <= ie_d;
      bd_q <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end
  // read mux from pre-edge state; unused register bits read as zero
  always_comb begin
    sr_val = '0;
    sr_val[IM_HI:IM_LO] = im_q;
    sr_val[SR_EXL] = exl_q;
    sr_val[SR_IE] = ie_q;
    cause_val = '0;
    cause_val[CAUSE_BD] = bd_q;
    cause_val[IP_HI:IP_LO] = ip_q;
    cause_val[EXC_HI:EXC_LO] = exc_q;
    CP0Out = CP0Add == REG_SR ? sr_val :
             CP0Add == REG_CAUSE ? cause_val :
             CP0Add == REG_EPC ? epc_q :
             CP0Add == REG_PRID ? PRID_VAL : 32'd0;
    EPCOut = epc_q;
  end
endmodule

// File: tb/tb_coproc0.sv
// tb_coproc0: directed vector table plus randomized run against a word-level CP0 model
module tb_coproc0;
  localparam logic [31:0] PRID = 32'h2022_0007;
  logic clk = 1'b0;
  logic reset, en, BDIn, EXLClr, Req;
  logic [4:0] CP0Add, ExcCodeIn;
  logic [5:0] HWInt;
  logic [31:0] CP0In, CP0Out, VPC, EPCOut;
  int total = 0;
  int bad = 0;
  logic [31:0] m_sr, m_cause, m_epc;

  coproc0 dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In), .CP0Out(CP0Out),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic en; logic [4:0] addr; logic [31:0] din; logic [31:0] vpc;
    logic bd; logic [4:0] code; logic [5:0] hw; logic clr;
    logic req; logic [31:0] out; logic [31:0] epc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic e, logic [4:0] a, logic [31:0] d, logic [31:0] v,
                              logic b, logic [4:0] c, logic [5:0] h, logic cl,
                              logic rq, logic [31:0] o, logic [31:0] ep);
    vec_t t;
    t.rst = rst; t.en = e; t.addr = a; t.din = d; t.vpc = v; t.bd = b; t.code = c; t.hw = h;
    t.clr = cl; t.req = rq; t.out = o; t.epc = ep;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t t);
    reset = t.rst; en = t.en; CP0Add = t.addr; CP0In = t.din; VPC = t.vpc;
    BDIn = t.bd; ExcCodeIn = t.code; HWInt = t.hw; EXLClr = t.clr;
  endtask

  function automatic logic [31:0] m_read(logic [4:0] a);
    return a == 5'd12 ? m_sr : a == 5'd13 ? m_cause : a == 5'd14 ? m_epc : a == 5'd15 ? PRID : 32'd0;
  endfunction

  function automatic logic m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || (ExcCodeIn != 5'd0 && !m_sr[1]);
  endfunction

  task automatic m_step();
    logic ir, rq;
    ir = m_int();
    rq = m_req();
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      if (rq) begin
        m_sr[1] = 1'b1;
        m_epc = BDIn ? VPC - 32'd4 : VPC;
        m_cause[31] = BDIn;
        m_cause[6:2] = ir ? 5'd0 : ExcCodeIn;
      end else begin
        if (en && CP0Add == 5'd12) m_sr = CP0In & 32'h0000_FC03;
        if (en && CP0Add == 5'd14) m_epc = CP0In;
        if (EXLClr) m_sr[1] = 1'b0;
      end
      m_cause[15:10] = HWInt;
    end
  endtask

  initial begin
    vec_t z;
    logic [4:0] codes [5];
    codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd8; codes[3] = 5'd10; codes[4] = 5'd12;
    z = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(z);
    @(negedge clk);
    @(negedge clk);
    tv.push_back(mk(0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 0, 15, 0, 0, 0, 0, 0, 0, 0, PRID, 32'h0));
    tv.push_back(mk(0, 1, 12, 32'h401, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 0, 12, 0, 32'h3000, 0, 0, 6'd1, 0, 1, 32'h401, 32'h0));
    tv.push_back(mk(0, 0, 13, 0, 32'h3abc, 0, 0, 6'd1, 0, 0, 32'h400, 32'h3000));
    tv.push_back(mk(0, 0, 12, 0, 0, 0, 0, 0, 1, 0, 32'h403, 32'h3000));
    tv.push_back(mk(0, 0, 14, 0, 32'h3008, 1, 10, 0, 0, 1, 32'h3000, 32'h3000));
    tv.push_back(mk(0, 0, 13, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0028, 32'h3004));
    tv.push_back(mk(0, 0, 14, 0, 32'h3010, 0, 12, 6'd1, 0, 1, 32'h3004, 32'h3004));
    tv.push_back(mk(0, 0, 13, 0, 0, 0, 0, 0, 1, 0, 32'h400, 32'h3010));
    tv.push_back(mk(0, 1, 14, 32'h3100, 32'h3020, 0, 8, 0, 0, 1, 32'h3010, 32'h3010));
    tv.push_back(mk(0, 0, 14, 0, 0, 0, 0, 0, 1, 0, 32'h3020, 32'h3020));
    tv.push_back(mk(0, 1, 14, 32'h3100, 0, 0, 0, 0, 0, 0, 32'h3020, 32'h3020));
    tv.push_back(mk(0, 0, 14, 0, 0, 0, 0, 0, 0, 0, 32'h3100, 32'h3100));
    tv.push_back(mk(0, 0, 12, 0, 32'h3040, 0, 8, 0, 1, 1, 32'h401, 32'h3100));
    tv.push_back(mk(0, 0, 12, 0, 32'h5000, 0, 4, 0, 0, 0, 32'h403, 32'h3040));
    tv.push_back(mk(1, 1, 15, 32'hffff_ffff, 32'h6000, 1, 5, 6'h3f, 1, 0, PRID, 32'h3040));
    tv.push_back(mk(0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 0, 15, 0, 0, 0, 0, 0, 0, 0, PRID, 32'h0));
    tv.push_back(mk(0, 1, 12, 32'hffff_fc03, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0));
    tv.push_back(mk(0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 32'hfc01, 32'h0));
    tv.push_back(mk(0, 1, 13, 32'hffff_ffff, 0, 0, 0, 6'h20, 0, 1, 32'h0, 32'h0));
    tv.push_back(mk(0, 0, 13, 0, 0, 0, 0, 6'h20, 0, 0, 32'h8000, 32'h0));
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("vec%0d_req", i), {31'd0, Req}, {31'd0, tv[i].req});
      chk($sformatf("vec%0d_cp0out", i), CP0Out, tv[i].out);
      chk($sformatf("vec%0d_epcout", i), EPCOut, tv[i].epc);
      @(posedge clk);
      @(negedge clk);
    end
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1;
    @(posedge clk);
    m_step();
    @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      en = $urandom_range(0, 1);
      CP0Add = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(11, 16));
      CP0In = $urandom;
      VPC = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      BDIn = $urandom_range(0, 1);
      ExcCodeIn = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 4)] : 5'd0;
      HWInt = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      EXLClr = ($urandom_range(0, 2) == 0);
      #1;
      chk($sformatf("rnd%0d_req", i), {31'd0, Req}, {31'd0, m_req()});
      chk($sformatf("rnd%0d_cp0out", i), CP0Out, m_read(CP0Add));
      chk($sformatf("rnd%0d_epcout", i), EPCOut, m_epc);
      @(posedge clk);
      m_step();
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
